// File: rtl/mul_pkg.sv
// Shared encodings for the sequential radix-4 Booth multiplier:
// RISC-V funct3[1:0] op codes, controller states and Booth digit selections.
package mul_pkg;

    localparam logic [1:0] MUL_OP    = 2'b00;
    localparam logic [1:0] MULH_OP   = 2'b01;
    localparam logic [1:0] MULHSU_OP = 2'b10;
    localparam logic [1:0] MULHU_OP  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_sel_e;

    // Radix-4 Booth recoding of the triplet {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_sel_e booth_decode(input logic [2:0] triplet);
        case (triplet)
            3'b001, 3'b010: return POS1;
            3'b011:         return POS2;
            3'b100:         return NEG2;
            3'b101, 3'b110: return NEG1;
            default:        return ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_radix4_pp_gen.sv
// Combinational radix-4 Booth partial-product selector. Negative digits are
// returned as the ones-complement plus a separate carry-in for the adder.
module booth_radix4_pp_gen
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       triplet,
    input  logic [WIDTH+1:0] mcand,
    output logic [WIDTH+2:0] pp,
    output logic             neg
);

    booth_sel_e       sel;
    logic [WIDTH+2:0] mag;

    always_comb begin
        sel = booth_decode(triplet);
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        mag = '0;
        case (sel)
            POS1, NEG1: mag = {mcand[WIDTH+1], mcand};
            POS2, NEG2: mag = {mcand, 1'b0};
            default:    mag = '0;
        endcase
        neg = (sel == NEG1) || (sel == NEG2);
        pp  = neg ? ~mag : mag;
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU, two multiplier
// bits per cycle. Optional MUL_ZERO_BYPASS_EN skips iteration for zero operands.
module booth_seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       funct,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product
);

    localparam int EXT    = WIDTH + 2;
    localparam int N_ITER = WIDTH / 2 + 1;
    localparam int CW     = $clog2(N_ITER + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(N_ITER - 1);

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   product_q, product_d;
    logic [1:0]         funct_q, funct_d;
    logic [EXT-1:0]     mcand_q, mcand_d;
    logic [2*EXT-1:0]   acc_q, acc_d;
    logic               prev_q, prev_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [EXT:0]       pp;
    logic               pp_neg;
    logic [EXT+1:0]     sum;
    logic [2*EXT-1:0]   acc_next;
    logic               sign_1, sign_2;

    booth_radix4_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
        .triplet (acc_q[1:0] == 2'b00 ? {2'b00, prev_q} : {acc_q[1:0], prev_q}),
        .mcand   (mcand_q),
        .pp      (pp),
        .neg     (pp_neg)
    );

    // Upper half is the running partial sum, lower half the unconsumed multiplier;
    // the two guard bits on the sum make the shift arithmetic and overflow-free.
    always_comb begin
        sum = {{2{acc_q[2*EXT-1]}}, acc_q[2*EXT-1:EXT]}
            + {pp[EXT], pp}
            + {{(EXT+1){1'b0}}, pp_neg};
        acc_next = {sum, acc_q[EXT-1:2]};
    end

    always_comb begin
        state_d   = state_q;
        product_d = product_q;
        funct_d   = funct_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        sign_1    = (funct != MULHU_OP);
        sign_2    = (funct == MUL_OP) || (funct == MULH_OP);

        case (state_q)
            IDLE: begin
                if (in_valid && !kill) begin
                    funct_d = funct;
                    mcand_d = {{2{sign_1 & operand_1[WIDTH-1]}}, operand_1};
                    acc_d   = {{EXT{1'b0}}, {2{sign_2 & operand_2[WIDTH-1]}}, operand_2};
                    prev_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = CALC;
`ifdef MUL_ZERO_BYPASS_EN
                    if ((operand_1 == '0) || (operand_2 == '0)) begin
                        product_d = '0;
                        state_d   = DONE;
                    end
`endif
                end
            end
            CALC: begin
                acc_d  = acc_next;
                prev_d = acc_q[1];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    product_d = (funct_q == MUL_OP) ? acc_next[WIDTH-1:0]
                                                    : acc_next[2*WIDTH-1:WIDTH];
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (kill) state_d = IDLE;

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            funct_q     <= MUL_OP;
            mcand_q     <= '0;
            acc_q       <= '0;
            prev_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
            funct_q     <= funct_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier: directed corner cases plus
// randomized operations checked against a 64-bit arithmetic reference model.
module tb_booth_seq_multiplier;

    localparam int W   = 32;
    localparam int LAT = W / 2 + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         kill = 1'b0;
    logic         out_ready = 1'b0;
    logic [1:0]   funct = 2'b00;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] product;

    int n_checks = 0;
    int n_fail   = 0;

    booth_seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .operand_1 (op1),
        .operand_2 (op2),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: extend each operand to 64 bits by the op's signedness, multiply, pick a half.
    function automatic logic [W-1:0] ref_mul(input logic [1:0] f, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [2*W-1:0] ea, eb, p;
        ea = (f == 2'b11) ? {{W{1'b0}}, a} : {{W{a[W-1]}}, a};
        eb = (f[1] == 1'b0) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        p  = ea * eb;
        return (f == 2'b00) ? p[W-1:0] : p[2*W-1:W];
    endfunction

    function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_ZERO_BYPASS_EN
        if (a == '0 || b == '0) return 1;
`endif
        return LAT;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_p,
                          input int exp_lat, input int hold);
        int           lat;
        logic         ir_low;
        logic [W-1:0] held;
        @(negedge clk);
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        funct = f; op1 = a; op2 = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        ir_low = 1'b1;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = c;
                break;
            end
            if (in_ready !== 1'b0) ir_low = 1'b0;
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".in_ready_busy"}, 64'(ir_low), 64'd1);
        check({tag, ".product"}, 64'(product), 64'(exp_p));
        held = product;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, ".hold_product"}, 64'(product), 64'(held));
            check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, ".after_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".after_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, ".after_product"}, 64'(product), 64'(exp_p));
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [1:0]   f;
        logic [W-1:0] a, b;

        // Reset state
        #12;
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.product", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed operations
        run_op("mul_7xm3", 2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT, 0);
        run_op("mulh_m1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT, 0);
        run_op("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, 0);
        run_op("mulhu_m1", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT, 0);
        run_op("mul_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, LAT, 0);
        run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT, 0);
        run_op("mulhsu_min", 2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, LAT, 0);
        run_op("mulhu_min", 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT, 0);

        // Backpressure: result held for 5 cycles
        run_op("backpressure", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0,
               ref_mul(2'b01, 32'h1234_5678, 32'h9ABC_DEF0), LAT, 5);

        // Kill during cycle 9 of CALC
        @(negedge clk);
        funct = 2'b00; op1 = 32'd11; op2 = 32'd13; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("kill.in_ready", 64'(in_ready), 64'd1);
        check("kill.out_valid", 64'(out_valid), 64'd0);
        expect_quiet("kill.no_result", 30);
        run_op("after_kill_3x5", 2'b00, 32'd3, 32'd5, 32'd15, LAT, 0);

        // Kill together with in_valid in IDLE: request is refused
        @(negedge clk);
        funct = 2'b00; op1 = 32'd9; op2 = 32'd9; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; kill = 1'b0;
        @(negedge clk);
        check("kill_idle.in_ready", 64'(in_ready), 64'd1);
        expect_quiet("kill_idle.no_result", 25);

        // Zero operand: bypass latency when enabled, full latency otherwise
        run_op("mulhu_zero", 2'b11, 32'h0000_0000, 32'h1234_5678, 32'h0,
               exp_latency(32'h0, 32'h1234_5678), 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            f = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       a = '0;
                1:       a = 32'h8000_0000;
                2:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = 32'h8000_0000;
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), f, a, b, ref_mul(f, a, b), exp_latency(a, b),
                   (i % 6 == 0) ? 2 : 0);
        end

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        funct = 2'b00; op1 = 32'd100; op2 = 32'd200; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset.in_ready", 64'(in_ready), 64'd1);
        check("midreset.out_valid", 64'(out_valid), 64'd0);
        check("midreset.product", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_quiet("midreset.no_result", 25);
        run_op("after_reset", 2'b00, 32'd100, 32'd200, 32'd20000, LAT, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_seq_multiplier.md
Name: booth_seq_multiplier

Overview:
- Iterative radix-4 Booth multiplier for the multicycle RISC-V core's M-extension datapath.
- Performs MUL, MULH, MULHSU and MULHU on WIDTH-bit operands.
- Consumes two multiplier bits per cycle and uses a valid/ready handshake on both input and output.
- Replaces the 8-bit combinational partial-product multiplier with a parametrised, sequential, area-lean unit.

Parameters:
- WIDTH, 32, operand and result width; must be even and at least 4.
- N_ITER, WIDTH/2+1, derived, not overridable; Booth iterations over the (WIDTH+2)-bit extended multiplier.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- funct  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; equal to RISC-V funct3[1:0].
- operand_1  input  WIDTH  multiplicand (rs1).
- operand_2  input  WIDTH  multiplier (rs2).
- kill  input  1  abort any in-flight operation.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- product  output  WIDTH  selected half of the 2*WIDTH product.

Behaviour:
- Reset values (rst_n low, asynchronous): state IDLE, in_ready 1, out_valid 0, product 0, all internal accumulators 0.
- State machine:
  - IDLE -> CALC on in_valid & in_ready & ~kill.
  - CALC -> DONE after N_ITER cycles.
  - DONE -> IDLE on out_ready.
  - Any state -> IDLE on kill.
- in_ready = (state == IDLE). No request is accepted in CALC or DONE.
- Capture: operands and funct are registered on the accepting edge.
- Operand extension to WIDTH+2 bits:
  - operand_1 is sign-extended for MUL, MULH and MULHSU; zero-extended for MULHU.
  - operand_2 is sign-extended for MUL and MULH; zero-extended for MULHSU and MULHU.
- Each CALC cycle:
  - Examine the Booth triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1] = 0.
  - Select 0, +M, +2M, -M or -2M; negation is ones-complement plus carry-in.
  - Add the selection into the upper half of a (2*WIDTH+4)-bit accumulator.
  - Arithmetic-shift the accumulator right by 2.
- Latency:
  - Accepting edge ends cycle 0; CALC occupies cycles 1..N_ITER; out_valid rises in cycle N_ITER+1.
  - For WIDTH=32 that is cycle 18.
  - Minimum issue-to-issue interval is N_ITER+2 cycles.
- Result selection: MUL returns product bits [WIDTH-1:0]. MULH, MULHSU and MULHU return bits [2*WIDTH-1:WIDTH].
- product is registered. It holds stable while out_valid & ~out_ready, and keeps its last value after handoff.
- Kill:
  - Any state goes to IDLE on the next edge; out_valid deasserts.
  - kill together with in_valid in IDLE: kill wins and the request is not accepted.
  - kill in DONE drops the result even if out_ready is high in the same cycle.
- Boundaries:
  - Most-negative operands (0x80000000 * 0x80000000) must be exact in all four modes.
  - funct values are all legal; there is no error state.
- Reset mid-CALC: immediate IDLE, no spurious out_valid.

Optional Feature:
- Macro MUL_ZERO_BYPASS_EN.
- Defined: if either operand is zero at acceptance, the unit goes straight from IDLE to DONE with product 0. out_valid rises in cycle 1.
- Undefined: zero operands take the full N_ITER path. The result is identical; only latency differs.

Decomposition:
- Package mul_pkg:
  - funct encodings MUL_OP, MULH_OP, MULHSU_OP, MULHU_OP.
  - State enum IDLE/CALC/DONE.
  - Booth select encoding (ZERO, POS1, POS2, NEG1, NEG2).
- Sub-module booth_radix4_pp_gen: combinational.
  - Inputs: triplet and the (WIDTH+2)-bit multiplicand.
  - Outputs: the (WIDTH+3)-bit selected partial product and a negate carry-in.
  - Parameterised by WIDTH.
  - Instantiated once in the iterative datapath.

Test Plan:
- MUL 7 * -3 (0x00000007, 0xFFFFFFFD): product 0xFFFFFFEB, out_valid in cycle 18, in_ready low during cycles 1..17.
- MULH / MULHSU / MULHU with 0xFFFFFFFF * 0xFFFFFFFF: products 0x00000000, 0xFFFFFFFF and 0xFFFFFFFE respectively.
- MULH 0x80000000 * 0x80000000: product 0x40000000. MUL on the same operands: product 0x00000000.
- Backpressure: hold out_ready low 5 cycles after out_valid; product stays stable and in_ready stays 0. On out_ready, IDLE the next cycle.
- Kill at cycle 9 of a CALC: out_valid never rises, in_ready is 1 the next cycle. A new MUL 3*5 then returns 15 normally.
- With MUL_ZERO_BYPASS_EN, MULHU 0 * 0x12345678 gives product 0 with out_valid in cycle 1. Without the macro, out_valid rises in cycle 18.
